// File: rtl/pair_drain_serializer.sv
// Drain stage for the pair-exit FIFO: issues slot-aligned read pulses, captures the returned
// pair word, drops empty words and streams valid words out as DATA_W-bit beats, LSB beat first.
module pair_drain_serializer #(
    parameter int WORD_W   = 192,
    parameter int DATA_W   = 32,
    parameter int SLOT     = 16,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [WORD_W-1:0] pair_word,
    output logic              read_ctrl,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    output logic              m_last,
    input  logic              m_ready,
    output logic [31:0]       pair_cnt,
    output logic [31:0]       empty_cnt,
    output logic              busy
);

    localparam int BEATS = WORD_W / DATA_W;
    localparam int PH_W  = $clog2(SLOT);
    localparam int BI_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [PH_W-1:0] PH_LAST   = PH_W'(SLOT - 1);
    localparam logic [PH_W-1:0] PH_PRE    = PH_W'(SLOT - 2);
    localparam logic [PH_W-1:0] LAT_END   = PH_W'(READ_LAT);
    localparam logic [BI_W-1:0] BEAT_LAST = BI_W'(BEATS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_SEND = 2'd3
    } state_t;

    state_t                          state_r, state_s;
    logic [PH_W-1:0]                 phase_r, phase_s;
    logic [PH_W-1:0]                 lat_cnt_r, lat_cnt_s;
    logic [BI_W-1:0]                 beat_idx_r, beat_idx_s;
    logic [WORD_W-1:0]               capture_r, capture_s;
    logic [31:0]                     pair_cnt_r, pair_cnt_s;
    logic [31:0]                     empty_cnt_r, empty_cnt_s;
    logic                            read_ctrl_r, read_ctrl_s;
    logic                            m_valid_r, m_valid_s;
    logic                            m_last_r, m_last_s;
    logic                            busy_r, busy_s;
    logic [DATA_W-1:0]               m_data_r, m_data_s;
    logic [BEATS-1:0][DATA_W-1:0]    beats_s;

    // Next-state, counters and next registered output values
    always_comb begin
        state_s     = state_r;
        lat_cnt_s   = lat_cnt_r;
        beat_idx_s  = beat_idx_r;
        capture_s   = capture_r;
        pair_cnt_s  = pair_cnt_r;
        empty_cnt_s = empty_cnt_r;
        read_ctrl_s = 1'b0;

        if (phase_r == PH_LAST) begin
            phase_s = {PH_W{1'b0}};
        end else begin
            phase_s = phase_r + {{(PH_W-1){1'b0}}, 1'b1};
        end

        case (state_r)
            ST_IDLE: begin
                // Request one cycle ahead so the registered pulse lands on the slot cycle
                if (enable && (phase_r == PH_PRE)) begin
                    state_s     = ST_REQ;
                    read_ctrl_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                state_s   = ST_WAIT;
                lat_cnt_s = {{(PH_W-1){1'b0}}, 1'b1};
            end
            ST_WAIT: begin
                if (lat_cnt_r == LAT_END) begin
                    capture_s = pair_word;
                    if (pair_word == {WORD_W{1'b0}}) begin
                        empty_cnt_s = empty_cnt_r + 32'd1;
                        state_s     = ST_IDLE;
                    end else begin
                        beat_idx_s = {BI_W{1'b0}};
                        state_s    = ST_SEND;
                    end
                end else begin
                    lat_cnt_s = lat_cnt_r + {{(PH_W-1){1'b0}}, 1'b1};
                end
            end
            ST_SEND: begin
                if (m_valid_r && m_ready) begin
                    if (beat_idx_r == BEAT_LAST) begin
                        pair_cnt_s = pair_cnt_r + 32'd1;
                        beat_idx_s = {BI_W{1'b0}};
                        state_s    = ST_IDLE;
                    end else begin
                        beat_idx_s = beat_idx_r + {{(BI_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    beat_idx_s = beat_idx_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        beats_s   = capture_s;
        m_valid_s = (state_s == ST_SEND);
        busy_s    = (state_s != ST_IDLE);
        if (state_s == ST_SEND) begin
            m_data_s = beats_s[beat_idx_s];
            m_last_s = (beat_idx_s == BEAT_LAST);
        end else begin
            m_data_s = {DATA_W{1'b0}};
            m_last_s = 1'b0;
        end
    end

    // State and output registers; reset realigns the phase so the first slot follows release
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            phase_r     <= PH_LAST;
            lat_cnt_r   <= {PH_W{1'b0}};
            beat_idx_r  <= {BI_W{1'b0}};
            capture_r   <= {WORD_W{1'b0}};
            pair_cnt_r  <= 32'd0;
            empty_cnt_r <= 32'd0;
            read_ctrl_r <= 1'b0;
            m_valid_r   <= 1'b0;
            m_last_r    <= 1'b0;
            m_data_r    <= {DATA_W{1'b0}};
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            phase_r     <= phase_s;
            lat_cnt_r   <= lat_cnt_s;
            beat_idx_r  <= beat_idx_s;
            capture_r   <= capture_s;
            pair_cnt_r  <= pair_cnt_s;
            empty_cnt_r <= empty_cnt_s;
            read_ctrl_r <= read_ctrl_s;
            m_valid_r   <= m_valid_s;
            m_last_r    <= m_last_s;
            m_data_r    <= m_data_s;
            busy_r      <= busy_s;
        end
    end

    assign read_ctrl = read_ctrl_r;
    assign m_data    = m_data_r;
    assign m_valid   = m_valid_r;
    assign m_last    = m_last_r;
    assign pair_cnt  = pair_cnt_r;
    assign empty_cnt = empty_cnt_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_pair_drain_serializer.sv
// Directed bench for pair_drain_serializer: slot timing table, beat ordering, stalls,
// disabled drain, back-to-back words and reset in the middle of a word.
module tb_pair_drain_serializer;

    localparam logic [191:0] WORD6 =
        192'h0000_0006_0000_0005_0000_0004_0000_0003_0000_0002_0000_0001;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         enable = 1'b0;
    logic [191:0] pair_word = 192'd0;
    logic         read_ctrl;
    logic [31:0]  m_data;
    logic         m_valid;
    logic         m_last;
    logic         m_ready = 1'b1;
    logic [31:0]  pair_cnt;
    logic [31:0]  empty_cnt;
    logic         busy;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int rc_hits = 0;
    int valid_hits = 0;
    logic rc_prev = 1'b0;

    typedef struct {
        int          cyc;
        logic        rc;
        logic        busy;
        logic [31:0] empty;
    } vec_t;
    vec_t vt[11];

    pair_drain_serializer dut (
        .clk(clk), .reset(reset), .enable(enable), .pair_word(pair_word),
        .read_ctrl(read_ctrl), .m_data(m_data), .m_valid(m_valid), .m_last(m_last),
        .m_ready(m_ready), .pair_cnt(pair_cnt), .empty_cnt(empty_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (read_ctrl) begin
            rc_hits++;
            chk("rc_single_cycle", {31'd0, rc_prev}, 32'd0);
        end
        if (m_valid) valid_hits++;
        rc_prev = read_ctrl;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) step();
        chk("rst_read_ctrl", {31'd0, read_ctrl}, 32'd0);
        chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_m_last", {31'd0, m_last}, 32'd0);
        chk("rst_m_data", m_data, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_pair_cnt", pair_cnt, 32'd0);
        chk("rst_empty_cnt", empty_cnt, 32'd0);
        reset = 1'b0;
        cyc = -1;
        rc_hits = 0;
        valid_hits = 0;
    endtask

    // Expects beat 0 presented now; optionally stalls at beat stall_idx for stall_n cycles
    task automatic recv_word(input int stall_idx, input int stall_n);
        for (int b = 0; b < 6; b++) begin
            chk("beat_valid", {31'd0, m_valid}, 32'd1);
            chk("beat_data", m_data, 32'(b + 1));
            chk("beat_last", {31'd0, m_last}, (b == 5) ? 32'd1 : 32'd0);
            if (b == stall_idx) begin
                m_ready = 1'b0;
                for (int s = 0; s < stall_n; s++) begin
                    step();
                    chk("stall_valid", {31'd0, m_valid}, 32'd1);
                    chk("stall_data", m_data, 32'(b + 1));
                    chk("stall_last", {31'd0, m_last}, 32'd0);
                    chk("stall_no_read", {31'd0, read_ctrl}, 32'd0);
                end
                m_ready = 1'b1;
            end
            step();
        end
        chk("word_done_valid", {31'd0, m_valid}, 32'd0);
        chk("word_done_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hits_snap;

        vt[0]  = '{14, 1'b0, 1'b0, 32'd0};
        vt[1]  = '{15, 1'b1, 1'b1, 32'd0};
        vt[2]  = '{16, 1'b0, 1'b1, 32'd0};
        vt[3]  = '{17, 1'b0, 1'b0, 32'd1};
        vt[4]  = '{30, 1'b0, 1'b0, 32'd1};
        vt[5]  = '{31, 1'b1, 1'b1, 32'd1};
        vt[6]  = '{32, 1'b0, 1'b1, 32'd1};
        vt[7]  = '{33, 1'b0, 1'b0, 32'd2};
        vt[8]  = '{47, 1'b1, 1'b1, 32'd2};
        vt[9]  = '{49, 1'b0, 1'b0, 32'd3};
        vt[10] = '{50, 1'b0, 1'b0, 32'd3};

        // Empty FIFO: slot timing and empty counting
        enable = 1'b1;
        pair_word = 192'd0;
        do_reset();
        for (int i = 0; i < 11; i++) begin
            while (cyc < vt[i].cyc) step();
            chk("t1_read_ctrl", {31'd0, read_ctrl}, {31'd0, vt[i].rc});
            chk("t1_busy", {31'd0, busy}, {31'd0, vt[i].busy});
            chk("t1_empty_cnt", empty_cnt, vt[i].empty);
        end
        chk("t1_never_valid", 32'(valid_hits), 32'd0);
        chk("t1_pulse_count", 32'(rc_hits), 32'd3);

        // Word present only in the capture cycle
        do_reset();
        while (cyc < 16) step();
        pair_word = WORD6;
        step();
        pair_word = 192'd0;
        recv_word(-1, 0);
        chk("t2_pair_cnt", pair_cnt, 32'd1);
        chk("t2_empty_cnt", empty_cnt, 32'd0);

        // Stall on beat 3, missed slot skipped, next pulse at first slot after IDLE
        pair_word = WORD6;
        do_reset();
        while (cyc < 17) step();
        recv_word(2, 10);
        chk("t3_end_cycle", 32'(cyc), 32'd33);
        chk("t3_pair_cnt", pair_cnt, 32'd1);
        hits_snap = rc_hits;
        while (cyc < 46) step();
        chk("t3_no_queued_pulse", 32'(rc_hits), 32'(hits_snap));
        chk("t3_rc_pre", {31'd0, read_ctrl}, 32'd0);
        step();
        chk("t3_rc_slot47", {31'd0, read_ctrl}, 32'd1);

        // Drain disabled
        enable = 1'b0;
        do_reset();
        repeat (100) step();
        chk("t4_no_pulses", 32'(rc_hits), 32'd0);
        chk("t4_busy", {31'd0, busy}, 32'd0);
        chk("t4_pair_cnt", pair_cnt, 32'd0);
        chk("t4_empty_cnt", empty_cnt, 32'd0);

        // Back-to-back words, one per slot
        enable = 1'b1;
        m_ready = 1'b1;
        pair_word = WORD6;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            while (cyc < 14 + 16 * k) step();
            chk("t6_rc_pre", {31'd0, read_ctrl}, 32'd0);
            step();
            chk("t6_rc_slot", {31'd0, read_ctrl}, 32'd1);
            while (cyc < 22 + 16 * k) step();
            chk("t6_last_beat", {31'd0, m_last}, 32'd1);
            chk("t6_pair_before", pair_cnt, 32'(k));
            step();
            chk("t6_pair_after", pair_cnt, 32'(k + 1));
        end
        chk("t6_empty_cnt", empty_cnt, 32'd0);

        // Reset in the middle of the fifth word
        while (cyc < 83) step();
        chk("t5_mid_valid", {31'd0, m_valid}, 32'd1);
        chk("t5_mid_data", m_data, 32'd3);
        reset = 1'b1;
        step();
        chk("t5_rst_valid", {31'd0, m_valid}, 32'd0);
        chk("t5_rst_busy", {31'd0, busy}, 32'd0);
        chk("t5_rst_pair_cnt", pair_cnt, 32'd0);
        chk("t5_rst_last", {31'd0, m_last}, 32'd0);
        reset = 1'b0;
        cyc = -1;
        rc_hits = 0;
        while (cyc < 14) step();
        chk("t5_rc_pre", {31'd0, read_ctrl}, 32'd0);
        chk("t5_no_early_pulse", 32'(rc_hits), 32'd0);
        step();
        chk("t5_rc_realigned", {31'd0, read_ctrl}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
